// File: rtl/ddr_rdata_buffer_if.sv
// ----------------------------------------------------------------------------
// ddr_rdata_buffer_if
// Bundles the signals between the DDR controller / AXI subordinate and the
// read-data buffer.
//   Controller side : rd_start, rd_tid, burst_size, cap_valid, cap_data -> buffer
//                     rd_ready                                          <- buffer
//   Subordinate side: ren                                               -> buffer
//                     rvalid, rdata, tid_out, rlast_out                 <- buffer
// The master modport is the environment (controller + subordinate).
// The slave modport is the buffer.
// ----------------------------------------------------------------------------
interface ddr_rdata_buffer_if;
    logic        rd_start;
    logic [1:0]  rd_tid;
    logic [1:0]  burst_size;
    logic        cap_valid;
    logic [15:0] cap_data;
    logic        rd_ready;
    logic        rvalid;
    logic [63:0] rdata;
    logic [1:0]  tid_out;
    logic        rlast_out;
    logic        ren;

    modport master (
        output rd_start, rd_tid, burst_size, cap_valid, cap_data, ren,
        input  rd_ready, rvalid, rdata, tid_out, rlast_out
    );

    modport slave (
        input  rd_start, rd_tid, burst_size, cap_valid, cap_data, ren,
        output rd_ready, rvalid, rdata, tid_out, rlast_out
    );
endinterface

// File: rtl/ddr_rdata_buffer.sv
// ----------------------------------------------------------------------------
// ddr_rdata_buffer
// Assembles captured DQ pairs into 64-bit words. Each word is tagged with the
// burst's transaction ID and a last-word flag. Words are queued in a
// first-word-fall-through FIFO with a registered head.
// Ports:
//   clk, n_rst : clock (rising edge) and asynchronous active-low reset
//   bus        : slave modport of ddr_rdata_buffer_if (capture in, read out)
//   ovf_err    : sticky flag. Set when a word is dropped on a full FIFO, or
//                when a capture arrives outside a burst.
// ----------------------------------------------------------------------------
module ddr_rdata_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    ddr_rdata_buffer_if.slave    bus,
    output logic                 ovf_err
);

    localparam logic [0:0]     IDLE      = 1'b0;
    localparam logic [0:0]     ASSEMBLE  = 1'b1;
    localparam logic [PTR_W:0] DEPTH_C   = (PTR_W+1)'(DEPTH);
    // A full 8-word burst must fit, so ready means count <= DEPTH-8.
    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 8);

    logic [0:0]       state_r;
    logic [1:0]       pair_r;
    logic [2:0]       word_cnt_r;
    logic [2:0]       last_idx_r;
    logic [1:0]       tid_r;
    logic [47:0]      word_r;

    logic [63:0]      mem_data [DEPTH];
    logic [1:0]       mem_tid  [DEPTH];
    logic             mem_last [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    logic             head_valid_r;
    logic [63:0]      head_data_r;
    logic [1:0]       head_tid_r;
    logic             head_last_r;
    logic             ovf_r;

    logic             push_s;
    logic             push_ok_s;
    logic             pop_s;
    logic             drop_s;
    logic [63:0]      push_word_s;
    logic             push_last_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W:0]   count_nxt_s;
    logic             load_head_s;
    logic [63:0]      head_data_nxt_s;
    logic [1:0]       head_tid_nxt_s;
    logic             head_last_nxt_s;

    // Push, pop and drop decisions and the next FIFO occupancy.
    always_comb begin
        push_s       = (state_r == ASSEMBLE) && bus.cap_valid && (pair_r == 2'd3);
        push_word_s  = {bus.cap_data, word_r};
        push_last_s  = (word_cnt_r == last_idx_r);
        pop_s        = bus.ren && head_valid_r;
        // A push into a full FIFO is accepted only when the same edge frees a slot.
        push_ok_s    = push_s && ((count_r != DEPTH_C) || pop_s);
        drop_s       = (push_s && !push_ok_s) || ((state_r == IDLE) && bus.cap_valid);
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        count_nxt_s  = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
            2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Next head entry. The incoming word bypasses storage when it becomes the
    // head on the same edge, which happens when the FIFO is empty after any pop.
    always_comb begin
        if (pop_s) begin
            load_head_s = (count_nxt_s != '0);
        end else begin
            load_head_s = (count_r == '0) && push_ok_s;
        end
        if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_data_nxt_s = push_word_s;
            head_tid_nxt_s  = tid_r;
            head_last_nxt_s = push_last_s;
        end else begin
            head_data_nxt_s = mem_data[rd_ptr_nxt_s];
            head_tid_nxt_s  = mem_tid[rd_ptr_nxt_s];
            head_last_nxt_s = mem_last[rd_ptr_nxt_s];
        end
    end

    // Burst tracking and word assembly FSM.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r    <= IDLE;
            pair_r     <= 2'd0;
            word_cnt_r <= 3'd0;
            last_idx_r <= 3'd0;
            tid_r      <= 2'd0;
            word_r     <= 48'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.rd_start) begin
                        tid_r      <= bus.rd_tid;
                        pair_r     <= 2'd0;
                        word_cnt_r <= 3'd0;
                        state_r    <= ASSEMBLE;
                        case (bus.burst_size)
                            2'd0:    last_idx_r <= 3'd0;
                            2'd1:    last_idx_r <= 3'd1;
                            2'd2:    last_idx_r <= 3'd3;
                            2'd3:    last_idx_r <= 3'd7;
                            default: last_idx_r <= 3'd0;
                        endcase
                    end
                end
                ASSEMBLE: begin
                    if (bus.cap_valid) begin
                        pair_r <= pair_r + 2'd1;
                        case (pair_r)
                            2'd0:    word_r[15:0]  <= bus.cap_data;
                            2'd1:    word_r[31:16] <= bus.cap_data;
                            2'd2:    word_r[47:32] <= bus.cap_data;
                            default: word_r        <= word_r;
                        endcase
                        if (pair_r == 2'd3) begin
                            word_cnt_r <= word_cnt_r + 3'd1;
                            if (push_last_s) begin
                                state_r <= IDLE;
                            end
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // FIFO storage. It holds no reset value because it is only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_data[wr_ptr_r] <= push_word_s;
            mem_tid[wr_ptr_r]  <= tid_r;
            mem_last[wr_ptr_r] <= push_last_s;
        end
    end

    // FIFO pointers, count, registered head and sticky overflow flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            head_valid_r <= 1'b0;
            head_data_r  <= 64'd0;
            head_tid_r   <= 2'd0;
            head_last_r  <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            head_valid_r <= (count_nxt_s != '0);
            if (load_head_s) begin
                head_data_r <= head_data_nxt_s;
                head_tid_r  <= head_tid_nxt_s;
                head_last_r <= head_last_nxt_s;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign bus.rd_ready  = (state_r == IDLE) && (count_r <= READY_MAX);
    assign bus.rvalid    = head_valid_r;
    assign bus.rdata     = head_data_r;
    assign bus.tid_out   = head_tid_r;
    assign bus.rlast_out = head_last_r;
    assign ovf_err       = ovf_r;

endmodule

// File: tb/tb_ddr_rdata_buffer.sv
// ----------------------------------------------------------------------------
// tb_ddr_rdata_buffer
// Directed bench for ddr_rdata_buffer (DEPTH = 16). A table of single-word
// bursts is followed by hand-written multi-cycle sequences that use a
// scoreboard queue of expected words.
// ----------------------------------------------------------------------------
module tb_ddr_rdata_buffer;

    localparam int DEPTH = 16;

    typedef struct {
        logic [1:0]  tid;
        logic [15:0] p0, p1, p2, p3;
        logic [63:0] exp_data;
        logic [1:0]  exp_tid;
        logic        exp_last;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  t;
        logic        l;
    } ent_t;

    logic clk = 1'b0;
    logic n_rst;
    logic ovf_err;

    always #5 clk = ~clk;

    ddr_rdata_buffer_if bus();

    ddr_rdata_buffer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .bus     (bus),
        .ovf_err (ovf_err)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt      = 0;
    logic auto_pop = 1'b0;
    logic phase    = 1'b0;
    ent_t expq[$];
    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare the current head against the oldest expected word and retire it.
    task automatic check_head();
        ent_t e;
        if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got rvalid=%0b expected no pop", bus.rvalid);
        end else begin
            e = expq.pop_front();
            check("head_valid", bus.rvalid, 1'b1);
            check("head_data", bus.rdata, e.d);
            check("head_tid", bus.tid_out, e.t);
            check("head_last", bus.rlast_out, e.l);
        end
    endtask

    task automatic tick();
        if (auto_pop) begin
            bus.ren = phase;
            if (bus.ren && bus.rvalid) begin
                check_head();
                cnt--;
            end
            phase = ~phase;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst          = 1'b0;
        bus.rd_start   = 1'b0;
        bus.rd_tid     = 2'd0;
        bus.burst_size = 2'd0;
        bus.cap_valid  = 1'b0;
        bus.cap_data   = 16'd0;
        bus.ren        = 1'b0;
        expq.delete();
        cnt = 0;
        #7;
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_rdata", bus.rdata, 64'd0);
        check("rst_tid", bus.tid_out, 2'd0);
        check("rst_rlast", bus.rlast_out, 1'b0);
        check("rst_ovf", ovf_err, 1'b0);
        check("rst_rd_ready", bus.rd_ready, 1'b1);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [1:0] t, input logic [1:0] bs, input logic chk_busy);
        bus.rd_start   = 1'b1;
        bus.rd_tid     = t;
        bus.burst_size = bs;
        tick();
        bus.rd_start = 1'b0;
        if (chk_busy) check("busy_after_start", bus.rd_ready, 1'b0);
    endtask

    // Send one word as four pairs. The word is enqueued when the model has room for it.
    task automatic send_word(input logic [63:0] w, input logic wl, input logic [1:0] wt,
                             input int max_gap, input logic chk_busy, input logic pop_last);
        for (int j = 0; j < 4; j++) begin
            if (chk_busy) check("rd_ready_busy", bus.rd_ready, 1'b0);
            bus.cap_valid = 1'b1;
            bus.cap_data  = w[16*j +: 16];
            if (j == 3) begin
                if (pop_last) begin
                    check_head();
                    bus.ren = 1'b1;
                    cnt--;
                end
                if (cnt < DEPTH) begin
                    expq.push_back('{d: w, t: wt, l: wl});
                    cnt++;
                end
            end
            tick();
            bus.cap_valid = 1'b0;
            if (pop_last && j == 3) bus.ren = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    function automatic logic [63:0] seq_word(input int base);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'(base + b);
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pp[4];
        logic [63:0] ww;
        vecs[0] = '{2'd2, 16'h1100, 16'h3322, 16'h5544, 16'h7766, 64'h7766554433221100, 2'd2, 1'b1};
        vecs[1] = '{2'd0, 16'hBEEF, 16'hDEAD, 16'h0001, 16'h8000, 64'h80000001DEADBEEF, 2'd0, 1'b1};
        vecs[2] = '{2'd3, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 64'h0000FFFF0000FFFF, 2'd3, 1'b1};
        vecs[3] = '{2'd1, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 64'hDEF09ABC56781234, 2'd1, 1'b1};

        do_reset();

        // Table: single-word bursts, word visible one cycle after the 4th pair.
        for (int i = 0; i < 4; i++) begin
            pp[0] = vecs[i].p0; pp[1] = vecs[i].p1; pp[2] = vecs[i].p2; pp[3] = vecs[i].p3;
            start_burst(vecs[i].tid, 2'd0, 1'b1);
            for (int j = 0; j < 4; j++) begin
                check("tbl_no_early_valid", bus.rvalid, 1'b0);
                bus.cap_valid = 1'b1;
                bus.cap_data  = pp[j];
                tick();
            end
            bus.cap_valid = 1'b0;
            check("tbl_rvalid", bus.rvalid, 1'b1);
            check("tbl_rdata", bus.rdata, vecs[i].exp_data);
            check("tbl_tid", bus.tid_out, vecs[i].exp_tid);
            check("tbl_rlast", bus.rlast_out, vecs[i].exp_last);
            check("tbl_rd_ready_idle", bus.rd_ready, 1'b1);
            bus.ren = 1'b1;
            tick();
            bus.ren = 1'b0;
            check("tbl_empty_after_pop", bus.rvalid, 1'b0);
        end

        // Burst of 8 with random capture gaps.
        start_burst(2'd1, 2'd3, 1'b1);
        for (int w = 0; w < 8; w++) send_word(seq_word(8*w), (w == 7), 2'd1, 2, 1'b1, 1'b0);
        check("b8_ready_after", bus.rd_ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check_head();
            bus.ren = 1'b1;
            cnt--;
            tick();
            bus.ren = 1'b0;
        end
        check("b8_drained", bus.rvalid, 1'b0);

        // Two back-to-back 8-word bursts fill the FIFO.
        for (int b = 0; b < 2; b++) begin
            start_burst((b == 0) ? 2'd0 : 2'd3, 2'd3, 1'b1);
            for (int w = 0; w < 8; w++)
                send_word(seq_word(64*b + 8*w), (w == 7), (b == 0) ? 2'd0 : 2'd3, 0, 1'b1, 1'b0);
            check("b2b_ready", bus.rd_ready, (b == 0));
        end
        // Push with simultaneous pop at full: accepted.
        start_burst(2'd2, 2'd0, 1'b0);
        send_word(64'hC0FFEE0012345678, 1'b1, 2'd2, 0, 1'b0, 1'b1);
        check("full_pushpop_ovf", ovf_err, 1'b0);
        check("full_pushpop_ready", bus.rd_ready, 1'b0);
        // Push at full without pop: dropped.
        start_burst(2'd2, 2'd0, 1'b0);
        send_word(64'hDEADDEADDEADDEAD, 1'b1, 2'd2, 0, 1'b0, 1'b0);
        check("full_drop_ovf", ovf_err, 1'b1);
        for (int k = 0; k < 40 && expq.size() > 0; k++) begin
            check_head();
            bus.ren = 1'b1;
            cnt--;
            tick();
            bus.ren = 1'b0;
            check("drain_rd_ready", bus.rd_ready, (cnt <= 8));
        end
        check("drain_empty", bus.rvalid, 1'b0);

        // Stray capture while idle.
        do_reset();
        bus.cap_valid = 1'b1;
        bus.cap_data  = 16'h5A5A;
        tick();
        bus.cap_valid = 1'b0;
        check("stray_ovf", ovf_err, 1'b1);
        tick();
        check("stray_nothing_queued", bus.rvalid, 1'b0);

        // Reset in the middle of a burst with a word already queued.
        start_burst(2'd0, 2'd0, 1'b0);
        send_word(64'h0102030405060708, 1'b1, 2'd0, 0, 1'b0, 1'b0);
        check("mid_queued", bus.rvalid, 1'b1);
        start_burst(2'd3, 2'd0, 1'b0);
        bus.cap_valid = 1'b1;
        bus.cap_data  = 16'hEEEE;
        tick();
        bus.cap_data  = 16'hDDDD;
        tick();
        bus.cap_valid = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        check("midrst_rvalid", bus.rvalid, 1'b0);
        check("midrst_ovf", ovf_err, 1'b0);
        check("midrst_ready", bus.rd_ready, 1'b1);
        expq.delete();
        cnt = 0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        start_burst(2'd1, 2'd0, 1'b1);
        send_word(64'h00FF00FF12345678, 1'b1, 2'd1, 0, 1'b0, 1'b0);
        check_head();
        bus.ren = 1'b1;
        cnt--;
        tick();
        bus.ren = 1'b0;
        check("midrst_fresh_empty", bus.rvalid, 1'b0);

        // Pointer wrap: 40 single-word bursts, ren pulsed every other cycle.
        auto_pop = 1'b1;
        phase    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ww = 64'd0;
            for (int j = 0; j < 4; j++) ww[16*j +: 16] = 16'(16'hA000 + i*4 + j);
            start_burst(2'(i % 4), 2'd0, 1'b0);
            send_word(ww, 1'b1, 2'(i % 4), 0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 100 && expq.size() > 0; k++) tick();
        auto_pop = 1'b0;
        bus.ren  = 1'b0;
        if (expq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wrap_timeout: got %0d words outstanding expected 0", expq.size());
        end
        tick();
        check("wrap_empty", bus.rvalid, 1'b0);
        check("wrap_ovf", ovf_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_rdata_buffer.md
Name: ddr_rdata_buffer

Overview:
- Sits between the DDR controller's read-capture path and the AXI subordinate.
- Assembles DQ pairs (rising-edge byte, falling-edge byte), already sampled into the clk domain by the controller, into 64-bit words.
- Tags each word with the burst's transaction ID and marks the last word of each burst.
- Queues words in a FIFO and presents them as rvalid/rdata/tid_out, popped by the subordinate's ren.
- Gives the controller a read-issue credit signal so a read burst is never started without room for it.

Parameters:
- DEPTH, 16, FIFO entries (64-bit word + tid + last); power of two, at least 8.
- PTR_W, $clog2(DEPTH), FIFO pointer width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- rd_start  input  1  pulse: controller begins a read burst.
- rd_tid  input  2  transaction ID of that burst; sampled on rd_start.
- burst_size  input  2  words in burst: 0→1, 1→2, 2→4, 3→8; sampled on rd_start.
- cap_valid  input  1  cap_data holds one DQ pair this cycle.
- cap_data  input  16  [7:0] = rising-edge byte, [15:8] = falling-edge byte.
- rd_ready  output  1  controller may assert rd_start.
- rvalid  output  1  FIFO head valid.
- rdata  output  64  head data word.
- tid_out  output  2  head transaction ID.
- rlast_out  output  1  head is the last word of its burst.
- ren  input  1  pop head; ignored when rvalid=0.
- ovf_err  output  1  sticky: a word was dropped on a full FIFO, or cap_valid arrived while IDLE.

Behaviour:
- Reset (async, n_rst=0): FSM=IDLE, pointers/count=0, rvalid=0, rdata=0, tid_out=0, rlast_out=0, ovf_err=0, rd_ready=1 (DEPTH≥8, empty). Reset mid-burst discards the partial word and all queued entries.
- FSM states IDLE and ASSEMBLE.
- IDLE:
  - rd_start=1 latches rd_tid and word target N (1/2/4/8), clears the pair counter (0..3) and word counter, and moves to ASSEMBLE the next cycle.
  - cap_valid in IDLE: data dropped, ovf_err←1.
- ASSEMBLE:
  - Each cap_valid writes cap_data into word bits [16*p+15:16*p], p = pair counter, then p increments. Little-endian: first pair lands in [15:0].
  - On the 4th pair (p=3) the completed word, including that pair, is pushed the same cycle with last = (word count == N-1). Pair counter wraps to 0 and word count increments.
  - After pushing the last word, return to IDLE the next cycle.
  - cap_valid gaps (cap_valid=0) are allowed and simply stall assembly.
  - rd_start while in ASSEMBLE is ignored. The controller must not issue it, because rd_ready=0 in that state.
- rd_ready = (state==IDLE) && (DEPTH − count ≥ 8). Combinational from registered state and count.
- FIFO:
  - Output is registered-head, first-word-fall-through: a word pushed at edge k appears with rvalid=1 after edge k (visible cycle k+1).
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Pop with rvalid=1 advances the head next edge; rdata/tid_out/rlast_out change only on a pop or when going non-empty.
  - Push while count==DEPTH and no simultaneous pop: word dropped, ovf_err←1, no pointer change. Push while full with a simultaneous pop: accepted.
  - Pointers are PTR_W bits and wrap modulo DEPTH; count is PTR_W+1 bits.
- ovf_err clears only on reset.

Test Plan:
- Single word: rd_start with rd_tid=2, burst_size=0; pairs 0x1100, 0x3322, 0x5544, 0x7766 on 4 consecutive cycles → one cycle after the 4th pair, rvalid=1, rdata=0x7766554433221100, tid_out=2, rlast_out=1; rd_ready=1 again after return to IDLE.
- Burst of 8 with gaps: burst_size=3, tid=1, 32 pairs with random cap_valid idles → 8 words in order, rlast_out=1 only on word 8, rd_ready=0 throughout the burst.
- Back-to-back bursts with ren held 0, DEPTH=16: two 8-word bursts fill the FIFO → rd_ready=0 after the second burst. Pop one word → rd_ready stays 0 until count≤8.
- Simultaneous push/pop at full: count=16, ren=1 on the same cycle as a push → count stays 16, new word at the tail, ovf_err=0. Same push with ren=0 → word dropped, ovf_err=1.
- Stray capture: cap_valid=1 while IDLE → nothing queued, ovf_err=1.
- Reset mid-burst: n_rst low after 2 of 4 pairs → rvalid=0 immediately, ovf_err=0. A fresh burst after release returns clean data with no residual bytes.
- Pointer wrap: stream 40 single-word bursts with ren pulsed every other cycle → all 40 words emerge in order with correct tid.
